// File: rtl/robot_pkg.sv
// rtl/robot_pkg.sv - command encodings, button indices and shared types for the move scheduler
package robot_pkg;

  typedef logic [2:0] cmd_t;
  typedef logic       src_t;

  typedef enum logic {
    S_IDLE,
    S_ISSUE
  } sched_state_t;

  localparam cmd_t CMD_NOP   = 3'd0;
  localparam cmd_t CMD_UP    = 3'd1;
  localparam cmd_t CMD_DOWN  = 3'd2;
  localparam cmd_t CMD_LEFT  = 3'd3;
  localparam cmd_t CMD_RIGHT = 3'd4;
  localparam cmd_t CMD_CLEAN = 3'd5;

  localparam src_t SRC_MANUAL = 1'b0;
  localparam src_t SRC_AUTO   = 1'b1;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_X     = 7;
  localparam int BTN_Y     = 8;
  localparam int BTN_Z     = 9;
  localparam int BTN_START = 10;
  localparam int NUM_BTNS  = 11;

  // Codes 6 and 7 are reserved and never reach the world.
  function automatic logic is_move_cmd(input cmd_t c);
    return (c >= CMD_UP) && (c <= CMD_CLEAN);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - synchronous FIFO with registered count, flush, and push-while-full when popping
module cmd_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full,
  output logic                     o_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_rd;
  logic             w_wr;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // A pop frees the slot in the same edge, so a full FIFO still takes the push.
  assign w_rd   = i_pop & ~o_empty & ~i_flush;
  assign w_wr   = i_push & ~i_flush & (~o_full | w_rd);
  assign o_drop = i_push & ~i_flush & o_full & ~w_rd;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/move_scheduler.sv
// rtl/move_scheduler.sv - sequences gamepad and autonomous moves into a one-at-a-time valid/ready stream
module move_scheduler
  import robot_pkg::*;
#(
  parameter int AUTO_PERIOD = 12_500_000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clock_50,
  input  logic                          reset_key,
  input  logic                          mode,
  input  logic [10:0]                   buttons,
  input  logic [2:0]                    auto_cmd,
  input  logic                          cmd_ready,
  output logic                          cmd_valid,
  output logic [2:0]                    cmd,
  output logic                          cmd_src,
  output logic                          paused,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int TW = $clog2(AUTO_PERIOD);
  localparam logic [TW-1:0] TICK_LAST = TW'(AUTO_PERIOD - 1);

  logic [NUM_BTNS-1:0] r_btn_q;
  logic [NUM_BTNS-1:0] r_btn_d;
  logic                r_mode;
  logic                r_paused;
  logic                r_overflow;
  logic [TW-1:0]       r_tick_cnt;
  sched_state_t        r_state;
  cmd_t                r_cmd;
  src_t                r_src;

  logic [NUM_BTNS-1:0] w_rise;
  logic                w_mode_chg;
  logic                w_tick;
  cmd_t                w_man_cmd;
  logic                w_man_push;
  logic                w_auto_push;
  logic                w_push;
  logic [3:0]          w_push_data;
  logic [3:0]          w_fifo_rdata;
  logic                w_fifo_empty;
  logic                w_fifo_full;
  logic                w_drop;
  logic                w_pop;
  sched_state_t        w_next_state;

  assign w_rise     = r_btn_q & ~r_btn_d;
  assign w_mode_chg = mode ^ r_mode;
  assign w_tick     = (r_tick_cnt == TICK_LAST);

  // Priority encoder over the gamepad; B, C, X, Y, Z and START are don't-cares here.
  always_comb begin
    w_man_cmd = CMD_NOP;
    casez (w_rise)
      11'b???_????_???1: w_man_cmd = CMD_UP;
      11'b???_????_??10: w_man_cmd = CMD_DOWN;
      11'b???_????_?100: w_man_cmd = CMD_LEFT;
      11'b???_????_1000: w_man_cmd = CMD_RIGHT;
      11'b???_???1_0000: w_man_cmd = CMD_CLEAN;
      default:           w_man_cmd = CMD_NOP;
    endcase
  end

  assign w_man_push  = ~mode & ~r_paused & (w_man_cmd != CMD_NOP);
  assign w_auto_push = mode & ~r_paused & w_tick & is_move_cmd(auto_cmd);
  assign w_push      = w_man_push | w_auto_push;
  assign w_push_data = mode ? {SRC_AUTO, auto_cmd} : {SRC_MANUAL, w_man_cmd};

  cmd_fifo #(
    .WIDTH (4),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk     (clock_50),
    .rst_n   (reset_key),
    .i_flush (w_mode_chg),
    .i_push  (w_push),
    .i_wdata (w_push_data),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_count (fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_drop  (w_drop)
  );

  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      r_btn_q    <= '0;
      r_btn_d    <= '0;
      r_mode     <= 1'b0;
      r_paused   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_btn_q <= buttons;
      r_btn_d <= r_btn_q;
      r_mode  <= mode;
      if (w_rise[BTN_START]) begin
        r_paused <= ~r_paused;
      end
      if (w_mode_chg) begin
        r_overflow <= 1'b0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Pause freezes the autonomous phase rather than restarting it.
  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      r_tick_cnt <= '0;
    end else if (w_mode_chg || !mode) begin
      r_tick_cnt <= '0;
    end else if (!r_paused) begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_paused && !w_fifo_empty && !w_mode_chg) begin
          w_pop        = 1'b1;
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      r_state <= S_IDLE;
      r_cmd   <= CMD_NOP;
      r_src   <= SRC_MANUAL;
    end else begin
      r_state <= w_next_state;
      if (w_pop) begin
        r_src <= w_fifo_rdata[3];
        r_cmd <= w_fifo_rdata[2:0];
      end
    end
  end

  assign cmd_valid = (r_state == S_ISSUE);
  assign cmd       = r_cmd;
  assign cmd_src   = r_src;
  assign paused    = r_paused;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_move_scheduler.sv
// tb/tb_move_scheduler.sv - scoreboard bench for move_scheduler with a queue-level reference model
module tb_move_scheduler;

  localparam int PERIOD = 8;
  localparam int DEPTH  = 4;

  logic        clock_50 = 1'b0;
  logic        reset_key;
  logic        mode;
  logic [10:0] buttons;
  logic [2:0]  auto_cmd;
  logic        cmd_ready;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic        cmd_src;
  logic        paused;
  logic [2:0]  fifo_count;
  logic        overflow;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int j        = 0;
  logic [3:0] exp_q[$];
  int         hs_cyc[$];

  always #5 clock_50 = ~clock_50;
  always @(posedge clock_50) cyc <= cyc + 1;

  move_scheduler #(.AUTO_PERIOD(PERIOD), .FIFO_DEPTH(DEPTH)) dut (
    .clock_50   (clock_50),
    .reset_key  (reset_key),
    .mode       (mode),
    .buttons    (buttons),
    .auto_cmd   (auto_cmd),
    .cmd_ready  (cmd_ready),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .cmd_src    (cmd_src),
    .paused     (paused),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  // Monitor: a handshake completes at the next rising edge whenever valid and ready are both high.
  always @(negedge clock_50) begin
    if (reset_key === 1'b1 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_cmd actual=%0h required=none", {cmd_src, cmd});
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        hs_cyc.push_back(cyc);
        if ({cmd_src, cmd} !== e) begin
          failures++;
          $display("FAIL cmd_order actual=%0h required=%0h", {cmd_src, cmd}, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock_50);
    #1;
  endtask

  // Gamepad meaning: lowest set bit among UP..A wins, command code is bit index + 1.
  function automatic logic [3:0] man_expect(input logic [10:0] b);
    for (int i = 0; i < 5; i++) begin
      if (b[i]) return {1'b0, 3'(i + 1)};
    end
    return 4'h0;
  endfunction

  task automatic press(input logic [10:0] b);
    buttons = b;
    tick();
    buttons = '0;
    tick();
  endtask

  task automatic press_expect(input logic [10:0] b);
    exp_q.push_back(man_expect(b));
    press(b);
  endtask

  // Auto model: every PERIOD-th cycle after the mode switch samples auto_cmd.
  task automatic auto_step(input logic [2:0] v);
    auto_cmd = v;
    if ((j % PERIOD) == PERIOD - 1 && v >= 3'd1 && v <= 3'd5) exp_q.push_back({1'b1, v});
    tick();
    j++;
  endtask

  initial begin
    int perm[5];
    int accepted;
    reset_key = 1'b0;
    mode      = 1'b0;
    buttons   = '0;
    auto_cmd  = '0;
    cmd_ready = 1'b1;
    repeat (3) @(posedge clock_50);
    #1;
    check("rst_valid", cmd_valid, 0);
    check("rst_cmd", cmd, 0);
    check("rst_src", cmd_src, 0);
    check("rst_paused", paused, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    reset_key = 1'b1;
    tick();
    tick();

    // Held LEFT: one command, valid two edges after first sample.
    exp_q.push_back({1'b0, 3'd3});
    buttons = 11'h004;
    tick();
    tick();
    check("left_valid_early", cmd_valid, 0);
    check("left_count", fifo_count, 1);
    tick();
    check("left_valid", cmd_valid, 1);
    check("left_cmd", cmd, 3);
    check("left_src", cmd_src, 0);
    repeat (3) tick();
    buttons = '0;
    repeat (6) tick();
    check("left_single", exp_q.size(), 0);

    // UP and RIGHT together: UP wins.
    exp_q.push_back({1'b0, 3'd1});
    buttons = 11'h009;
    tick();
    tick();
    check("upright_count", fifo_count, 1);
    buttons = '0;
    repeat (6) tick();
    check("upright_single", exp_q.size(), 0);
    check("upright_empty", fifo_count, 0);

    // Six rises into a stalled world: one in flight, four queued, one dropped.
    for (int i = 0; i < 5; i++) perm[i] = i;
    for (int i = 4; i > 0; i--) begin
      int k;
      int t;
      k = $urandom_range(0, i);
      t = perm[i];
      perm[i] = perm[k];
      perm[k] = t;
    end
    cmd_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      logic [10:0] b;
      b = 11'(1) << (i < 5 ? perm[i] : $urandom_range(0, 4));
      if (accepted < 1 + DEPTH) begin
        exp_q.push_back(man_expect(b));
        accepted++;
      end
      press(b);
    end
    tick();
    tick();
    check("ovf_count", fifo_count, 4);
    check("ovf_flag", overflow, 1);
    check("ovf_valid", cmd_valid, 1);
    cmd_ready = 1'b1;
    repeat (14) tick();
    check("ovf_drained", exp_q.size(), 0);
    check("ovf_sticky", overflow, 1);

    // Autonomous pacing.
    mode = 1'b1;
    tick();
    check("mode_clears_ovf", overflow, 0);
    j = 0;
    hs_cyc.delete();
    repeat (3 * PERIOD) auto_step(3'd2);
    for (int i = 0; i < PERIOD; i++) begin
      buttons = (i == 2) ? 11'h004 : 11'h000;
      auto_step(3'd0);
    end
    buttons = '0;
    repeat (PERIOD) auto_step(3'd7);
    check("auto_issue_count", hs_cyc.size(), 3);
    if (hs_cyc.size() >= 3) begin
      check("auto_spacing_a", hs_cyc[1] - hs_cyc[0], PERIOD);
      check("auto_spacing_b", hs_cyc[2] - hs_cyc[1], PERIOD);
    end
    repeat (6 * PERIOD) auto_step(3'($urandom_range(0, 7)));
    repeat (PERIOD + 2) auto_step(3'd0);
    check("auto_drained", exp_q.size(), 0);
    mode = 1'b0;
    repeat (3) tick();

    // Pause with three queued behind an in-flight command.
    cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) press_expect(11'(1) << $urandom_range(0, 4));
    tick();
    check("pause_prefill", fifo_count, 3);
    press(11'h400);
    check("pause_on", paused, 1);
    cmd_ready = 1'b1;
    repeat (6) tick();
    check("pause_held", fifo_count, 3);
    check("pause_no_valid", cmd_valid, 0);
    press(11'h001);
    tick();
    check("pause_no_push", fifo_count, 3);
    check("pause_no_ovf", overflow, 0);
    press(11'h400);
    check("pause_off", paused, 0);
    repeat (10) tick();
    check("pause_drained", exp_q.size(), 0);
    check("pause_empty", fifo_count, 0);

    // Asynchronous reset in the middle of a handshake while paused.
    cmd_ready = 1'b0;
    press_expect(11'h001);
    press_expect(11'h002);
    tick();
    check("prereset_valid", cmd_valid, 1);
    check("prereset_count", fifo_count, 1);
    press(11'h400);
    check("prereset_paused", paused, 1);
    #2;
    reset_key = 1'b0;
    #1;
    check("async_valid", cmd_valid, 0);
    check("async_cmd", cmd, 0);
    check("async_src", cmd_src, 0);
    check("async_paused", paused, 0);
    check("async_count", fifo_count, 0);
    check("async_overflow", overflow, 0);
    exp_q.delete();
    tick();
    tick();
    reset_key = 1'b1;
    repeat (3) tick();
    check("postreset_valid", cmd_valid, 0);
    check("postreset_count", fifo_count, 0);
    cmd_ready = 1'b1;
    press_expect(11'h008);
    repeat (4) tick();
    check("postreset_works", exp_q.size(), 0);

    // Mode toggle flushes the queue but leaves the in-flight command alone.
    cmd_ready = 1'b0;
    press_expect(11'h001);
    press_expect(11'h004);
    press_expect(11'h010);
    tick();
    check("flush_prefill", fifo_count, 2);
    mode = 1'b1;
    tick();
    tick();
    check("flush_count", fifo_count, 0);
    check("flush_keeps_valid", cmd_valid, 1);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    cmd_ready = 1'b1;
    repeat (3) tick();
    mode = 1'b0;
    repeat (3) tick();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/move_scheduler.md
# move_scheduler

Sequences robot movement commands between the gamepad path and an autonomous policy, and issues them one at a time to `world` over a valid/ready handshake. It sits between `controller` (its `buttonsOut`) and `world`. It edge-detects buttons, queues commands in a 4-deep FIFO, and paces autonomous steps with a tick counter. It also owns the pause state toggled by START.

## Interface
- `AUTO_PERIOD`, default 12_500_000: cycles between autonomous steps (0.25 s at 50 MHz); legal range ≥ 2.
- `FIFO_DEPTH`, default 4: command queue depth (power of two).
- `clock_50`, in, 1: system clock; the only clock.
- `reset_key`, in, 1: reset; one clock; reset is asynchronous and active-low.
- `mode`, in, 1: 0 = manual (gamepad), 1 = autonomous.
- `buttons`, in, 11: debounced, active-high buttons from `controller`; bit 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 A, 5 B, 6 C, 7 X, 8 Y, 9 Z, 10 START.
- `auto_cmd`, in, 3: command proposed by the autonomous policy; sampled on tick.
- `cmd_ready`, in, 1: `world` accepts the current command.
- `cmd_valid`, out, 1: command presented.
- `cmd`, out, 3: NOP=0, UP=1, DOWN=2, LEFT=3, RIGHT=4, CLEAN=5; 6 and 7 are reserved.
- `cmd_src`, out, 1: 0 = manual, 1 = autonomous.
- `paused`, out, 1: pause state.
- `fifo_count`, out, 3: number of queued entries (0..4).
- `overflow`, out, 1: sticky flag; a push was dropped.

## Operation
- `buttons` is registered to `btn_q`, then to `btn_d`. Rise = `btn_q & ~btn_d`.
- Manual mode, not paused: at most one push per cycle. Priority UP > DOWN > LEFT > RIGHT > A; A maps to CLEAN. B, C, X, Y and Z are ignored.
- START rise toggles `paused` in both modes.
- Auto mode, not paused: the tick counter runs 0..AUTO_PERIOD-1 and wraps. Tick = (count == AUTO_PERIOD-1). On tick, `auto_cmd` is pushed if it is 1..5. NOP and reserved codes are discarded.
- In manual mode the counter is held at 0. In auto mode, button rises other than START are ignored.
- Each FIFO entry carries `cmd` plus `src`.
- Push while full is dropped and sets `overflow`. Exception: if a pop occurs in the same cycle, the push is accepted and the count is unchanged.
- A change of `mode` (registered edge) does the following:
  - flushes the FIFO;
  - clears `overflow`;
  - zeroes the counter.
  - An in-flight `cmd_valid` is not affected.
- Pause blocks pops and pushes. Queued entries are retained. An in-flight command completes normally.
- FSM states:
  - IDLE, with `cmd_valid`=0: if not paused and the FIFO is non-empty, pop into the output register and go to ISSUE.
  - ISSUE, with `cmd_valid`=1: `cmd` and `cmd_src` are held stable. On `cmd_ready`, go to IDLE.
  - Leaving ISSUE always passes through one IDLE cycle, so there is at most one issue per two cycles.
- All outputs reset to 0. Reset mid-handshake drops `cmd_valid` immediately (asynchronous), empties the FIFO, and clears pause.

## Timing
- Button first sampled high at edge N: rise detected after N, FIFO write at N+1, pop at N+2. `cmd_valid` is high from N+2.
- Tick at edge T (count == AUTO_PERIOD-1): push at T, `cmd_valid` from T+1 if IDLE and the FIFO was empty.
- `cmd_ready` sampled high at edge R: `cmd_valid` is low after R. The next command is valid no earlier than R+2.
- START rise detected after edge N: `paused` toggles at N+1.
- `fifo_count` reflects pushes and pops registered at the same edge.

## Structure
- Package `robot_pkg`:
  - command encodings;
  - button bit indices;
  - the `cmd_t` (3-bit) and `src_t` (1-bit) typedefs.
- Sub-module `cmd_fifo`: synchronous FIFO with parameterised width/depth, registered count, and same-cycle push/pop support when full.
- The edge detector, tick counter and FSM stay in `move_scheduler`.

## Test plan
- Manual, `cmd_ready` tied 1: pulse LEFT (bit 2) for 5 cycles → exactly one `cmd`=3, `cmd_src`=0, `cmd_valid` high 2 cycles after first sampling. One issue only despite the held button.
- UP and RIGHT rise in the same cycle → one `cmd`=1. RIGHT is not queued; `fifo_count` peaks at 1.
- `cmd_ready`=0, 6 distinct button rises → 1 in ISSUE, 4 queued, `fifo_count`=4, `overflow`=1. Release ready → 5 commands, in order.
- Auto, AUTO_PERIOD=8, `auto_cmd`=2 → `cmd`=2, `cmd_src`=1 every 8 cycles. `auto_cmd`=0 → no issue. `auto_cmd`=7 → no issue.
- START rise with 3 queued, `cmd_ready`=1 → `paused`=1, queue held at 3, no `cmd_valid`. Second START rise → 3 commands drain.
- Assert `reset_key`=0 while `cmd_valid`=1 → all outputs 0 asynchronously. After release, IDLE with an empty FIFO. Toggling `mode` with 2 queued → `fifo_count`=0.
